// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared types and frame helpers for the SPI command master
package spi_cmd_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } spi_req_t;

  // Command byte {rw, 0, addr} followed by the data byte; reads send 0x00.
  function automatic logic [FRAME_BITS-1:0] build_frame(spi_req_t r);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[DATA_W + CMD_RW_BIT]   = r.write;
    f[DATA_W +: ADDR_W]      = r.addr;
    f[DATA_W-1:0]            = r.write ? r.wdata : '0;
    return f;
  endfunction

endpackage

// File: rtl/spi_cmd_master_if.sv
// rtl/spi_cmd_master_if.sv - request/response bundle between sequencer and SPI command master
interface spi_cmd_master_if;
  import spi_cmd_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/spi_req_fifo.sv
// rtl/spi_req_fifo.sv - 2-deep request FIFO, used only when SPI_CMD_MASTER_QUEUE_EN is defined
module spi_req_fifo
  import spi_cmd_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  spi_req_t push_data,
  input  logic     pop,
  output spi_req_t pop_data,
  output logic     full,
  output logic     empty
);

  spi_req_t   mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI mode-0 initiator for two-byte register command frames
// Optional request queue: define SPI_CMD_MASTER_QUEUE_EN.
module spi_cmd_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_cmd_master_if.slave bus,
  output logic            sclk,
  output logic            cs_n,
  output logic            mosi,
  input  logic            miso
);
  import spi_cmd_pkg::*;

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            bit_cnt;
  logic                  sck;
  logic                  tail;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [DATA_W-1:0]     rx_sr;
  logic                  start;
  logic                  have_req;
  spi_req_t              start_req;
  logic                  div_done;
  logic                  shift_fall;
  logic                  last_bit;
  logic                  active;

`ifdef SPI_CMD_MASTER_QUEUE_EN
  spi_req_t push_req;
  logic     fifo_full;
  logic     fifo_empty;

  assign push_req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};

  spi_req_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.req_valid),
    .push_data (push_req),
    .pop       (start),
    .pop_data  (start_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.req_ready = !fifo_full;
  assign have_req      = !fifo_empty;
`else
  assign start_req     = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
  assign bus.req_ready = (state == IDLE);
  assign have_req      = bus.req_valid;
`endif

  assign bus.busy   = (state != IDLE);
  assign div_done   = (cnt == DIV_LAST);
  assign shift_fall = (state == SHIFT) && div_done && sck;
  assign last_bit   = (bit_cnt == 4'(FRAME_BITS - 1));
  assign active     = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // tail marks the final low half-period after the 16th falling edge.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    case (state)
      IDLE:  if (have_req) begin
               state_d = SETUP;
               start   = 1'b1;
             end
      SETUP: if (div_done) state_d = SHIFT;
      SHIFT: if (div_done && tail) state_d = HOLD;
      HOLD:  if (div_done) state_d = GAP;
      GAP:   if (cnt == GAP_LAST) begin
               state_d = IDLE;
`ifdef SPI_CMD_MASTER_QUEUE_EN
               if (have_req) begin
                 state_d = SETUP;
                 start   = 1'b1;
               end
`endif
             end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the internal state, so they trail it by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      bit_cnt       <= '0;
      sck           <= 1'b0;
      tail          <= 1'b0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      sclk          <= 1'b0;
      cs_n          <= 1'b1;
      mosi          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      if (state == IDLE || state_d != state || (state == SHIFT && div_done)) cnt <= '0;
      else                                                                    cnt <= cnt + CNT_W'(1);

      if (state == SETUP && div_done)               sck <= 1'b1;
      else if (state == SHIFT && div_done && !tail) sck <= ~sck;

      if (start) begin
        tx_sr   <= build_frame(start_req);
        bit_cnt <= '0;
        tail    <= 1'b0;
      end else if (shift_fall) begin
        if (last_bit) begin
          tail <= 1'b1;
        end else begin
          tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      if (sck && !sclk) rx_sr <= {rx_sr[DATA_W-2:0], miso};

      sclk          <= sck;
      cs_n          <= !active;
      mosi          <= active && tx_sr[FRAME_BITS-1];
      bus.rsp_valid <= (state == GAP) && (cnt == '0);
      if (state == GAP && cnt == '0) bus.rsp_rdata <= rx_sr;
    end
  end

endmodule
